mca_operand_sequencer: RTL and testbench
========================================

Name: mca_operand_sequencer

Overview:
- Initiator side of the multi-cycle adder interface.
- Accepts operands one per cycle over a valid/ready stream and buffers NUM_ADDITIONS of them.
- Issues a one-cycle start to the adder, holds the operand vector stable while the adder runs, waits the fixed adder latency, then captures the sum and presents it on a valid/ready output.
- Sits between the per-channel coefficient/product generators and the downsampling accumulator.

Parameters:
WIDTH_COEFFICIENT, 32, width of every operand and of the result (signed)
NUM_ADDITIONS, 16, operands per sum (1..16)
MCA_LATENCY, 16, enabled clock edges from the adder leaving idle to its result register updating

Ports:
clk  in  1  clock
resetn  in  1  asynchronous, active-low reset
enable  in  1  global clock-enable, forwarded unchanged to the adder
in_valid  in  1  operand available
in_data  in  WIDTH_COEFFICIENT  signed operand
in_ready  out  1  operand accepted when in_valid & in_ready
mca_start  out  1  start pulse to adder
mca_enable  out  1  equal to enable (combinational)
mca_operands  out  NUM_ADDITIONS x WIDTH_COEFFICIENT  operand buffer to adder
mca_res  in  WIDTH_COEFFICIENT  adder result
out_valid  out  1  sum available
out_data  out  WIDTH_COEFFICIENT  captured signed sum
out_ready  in  1  downstream accepts sum
busy  out  1  high in any state except LOAD

Behaviour:
- Reset values: state LOAD, wr_idx 0, wait_cnt 0, all buffer entries 0, out_data 0, out_valid 0, mca_start 0.
- Reset mid-operation discards all buffered operands and any pending result. The adder shares resetn.
- With enable low, no state, counter or buffer changes occur. in_ready = (state==LOAD) & enable.
- LOAD:
  - On an accepted beat, buffer[wr_idx] <= in_data and wr_idx increments.
  - The beat with wr_idx==NUM_ADDITIONS-1 resets wr_idx to 0 and moves to START.
- START:
  - mca_start=1, decoded from state, so it lasts exactly one enabled cycle.
  - The next enabled edge moves to WAIT with wait_cnt=0.
- WAIT:
  - wait_cnt increments on each enabled edge.
  - When wait_cnt==MCA_LATENCY-1, the enabled edge moves to CAPTURE and clears wait_cnt.
- CAPTURE:
  - The next enabled edge loads out_data <= mca_res, sets out_valid=1 and moves to OUT.
- OUT:
  - Holds out_data and out_valid until out_valid & out_ready.
  - The handshake is independent of enable.
  - On the handshake edge, out_valid <= 0 and the state moves to LOAD.
- Latency: with enable held high, the start cycle's edge is E0 and out_valid rises after edge E0+MCA_LATENCY+1 (E17 by default).
- mca_operands change only in LOAD, so they are stable from the START cycle through CAPTURE.
- Arithmetic: no arithmetic is done here. The sum wraps modulo 2^WIDTH_COEFFICIENT inside the adder and is captured as-is.
- in_valid asserted outside LOAD is ignored, and no data is lost because in_ready=0.
- Back-to-back operation: a new LOAD starts in the cycle after the out handshake. Throughput is at most one sum per NUM_ADDITIONS+MCA_LATENCY+3 cycles.

Test Plan:
- Load operands 1..16 continuously, enable=1, out_ready=1 -> mca_start high for exactly 1 cycle, out_data=136, out_valid rises 17 cycles after the start cycle.
- Operands 0x7FFFFFFF, 1, then fourteen 0 -> out_data=0x80000000 (wraparound); operands -5 x16 -> out_data=-80.
- in_valid toggled 1,0 every cycle during load -> only valid beats stored; sum of 16 beats of value 3 equals 48; in_ready=0 throughout START..OUT.
- Deassert enable for 5 cycles mid-WAIT -> out_valid delayed by exactly 5 cycles, result unchanged; mca_operands constant for the whole START..CAPTURE window.
- Hold out_ready=0 for 10 cycles after out_valid -> out_data held, in_ready=0, busy=1; release -> LOAD the next cycle, second sum (10 x16 = 160) correct.
- Assert resetn low during WAIT -> all outputs return to reset values; subsequent full load of 2 x16 -> out_data=32.

Source files
------------

// File: rtl/mca_operand_sequencer.sv
// Initiator side of the multi-cycle adder: gathers NUM_ADDITIONS operands, kicks the
// adder, waits out its fixed latency and hands the captured sum downstream.

module mca_operand_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (we) data_d = d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) data_q <= '0;
        else         data_q <= data_d;
    end

    assign q = data_q;
endmodule

module mca_operand_sequencer #(
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int NUM_ADDITIONS     = 16,
    parameter int MCA_LATENCY       = 16
) (
    input  logic                                              clk,
    input  logic                                              resetn,
    input  logic                                              enable,
    input  logic                                              in_valid,
    input  logic [WIDTH_COEFFICIENT-1:0]                      in_data,
    output logic                                              in_ready,
    output logic                                              mca_start,
    output logic                                              mca_enable,
    output logic [NUM_ADDITIONS-1:0][WIDTH_COEFFICIENT-1:0]   mca_operands,
    input  logic [WIDTH_COEFFICIENT-1:0]                      mca_res,
    output logic                                              out_valid,
    output logic [WIDTH_COEFFICIENT-1:0]                      out_data,
    input  logic                                              out_ready,
    output logic                                              busy
);
    localparam int W     = WIDTH_COEFFICIENT;
    localparam int IDX_W = (NUM_ADDITIONS > 1) ? $clog2(NUM_ADDITIONS) : 1;
    localparam int CNT_W = $clog2(MCA_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ADDITIONS - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MCA_LATENCY - 1);

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } state_e;

    state_e             state_d, state_q;
    logic [IDX_W-1:0]   wr_idx_d, wr_idx_q;
    logic [CNT_W-1:0]   wait_cnt_d, wait_cnt_q;
    logic               out_valid_d, out_valid_q;
    logic [W-1:0]       out_data_d, out_data_q;
    logic               accept;
    logic [NUM_ADDITIONS-1:0] slot_we;

    assign in_ready   = (state_q == LOAD) & enable;
    assign accept     = in_valid & in_ready;
    assign mca_start  = (state_q == START);
    assign mca_enable = enable;
    assign busy       = (state_q != LOAD);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    // Buffer slots only take writes in LOAD, which keeps the adder's operands
    // frozen from START through CAPTURE.
    for (genvar g = 0; g < NUM_ADDITIONS; g++) begin : g_slot
        assign slot_we[g] = accept & (wr_idx_q == IDX_W'(g));
        mca_operand_slot #(.W(W)) u_slot (
            .clk    (clk),
            .resetn (resetn),
            .we     (slot_we[g]),
            .d      (in_data),
            .q      (mca_operands[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        wait_cnt_d  = wait_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = START;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            START: begin
                if (enable) begin
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (enable) begin
                    if (wait_cnt_q == LAST_WAIT) begin
                        wait_cnt_d = '0;
                        state_d    = CAPTURE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (enable) begin
                    out_data_d  = mca_res;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                // Downstream handshake deliberately ignores enable.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            wait_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_mca_operand_sequencer.sv
// Directed bench for mca_operand_sequencer with a behavioural multi-cycle adder
// that poisons its result while running and updates MCA_LATENCY enabled edges later.

module tb_mca_operand_sequencer;
    localparam int W   = 32;
    localparam int N   = 16;
    localparam int LAT = 16;

    logic                 clk = 1'b0;
    logic                 resetn, enable, in_valid, in_ready;
    logic [W-1:0]         in_data;
    logic                 mca_start, mca_enable;
    logic [N-1:0][W-1:0]  mca_operands;
    logic [W-1:0]         mca_res;
    logic                 out_valid, out_ready, busy;
    logic [W-1:0]         out_data;

    int total = 0;
    int fails = 0;
    logic [W-1:0] ops [N];

    mca_operand_sequencer #(
        .WIDTH_COEFFICIENT(W), .NUM_ADDITIONS(N), .MCA_LATENCY(LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mca_start(mca_start), .mca_enable(mca_enable), .mca_operands(mca_operands),
        .mca_res(mca_res), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Adder model: leaves idle on the start edge, result lands LAT enabled edges later.
    logic       add_run;
    int         add_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            add_run <= 1'b0;
            add_cnt <= 0;
            mca_res <= '0;
        end else if (mca_enable) begin
            if (!add_run) begin
                if (mca_start) begin
                    add_run <= 1'b1;
                    add_cnt <= 0;
                    mca_res <= 32'hDEAD_BEEF;
                end
            end else if (add_cnt == LAT - 1) begin
                logic [W-1:0] s;
                s = '0;
                for (int i = 0; i < N; i++) s = s + mca_operands[i];
                mca_res <= s;
                add_run <= 1'b0;
            end else begin
                add_cnt <= add_cnt + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) ops[i] = v;
    endtask

    // Feeds ops[]; with gaps, an idle cycle with junk data follows every beat but the last.
    task automatic load(input bit gaps);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = ops[i];
            step();
            if (gaps && i < N - 1) begin
                in_valid = 1'b0;
                in_data  = 32'hFFFF_FFFF;
                step();
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("start_pulse", {31'b0, mca_start}, 32'd1);
    endtask

    // Runs from the START cycle until out_valid; n counts edges starting with the start edge.
    task automatic wait_out(input string tag, input int stall_at, input int stall_len, output int n);
        logic [N-1:0][W-1:0] snap;
        bit stable, no_rdy, no_start, en_ok;
        snap = mca_operands;
        stable = 1; no_rdy = 1; no_start = 1; en_ok = 1;
        n = 0;
        while (!out_valid && n < 200) begin
            if (stall_len > 0 && n == stall_at)        enable = 1'b0;
            if (stall_len > 0 && n == stall_at + stall_len) enable = 1'b1;
            step();
            n++;
            if (mca_operands !== snap) stable = 0;
            if (in_ready !== 1'b0)     no_rdy = 0;
            if (mca_start !== 1'b0)    no_start = 0;
            if (mca_enable !== enable) en_ok = 0;
        end
        enable = 1'b1;
        check({tag, "_operands_stable"}, {31'b0, stable}, 32'd1);
        check({tag, "_in_ready_low"},    {31'b0, no_rdy}, 32'd1);
        check({tag, "_start_once"},      {31'b0, no_start}, 32'd1);
        check({tag, "_mca_enable"},      {31'b0, en_ok}, 32'd1);
    endtask

    initial begin
        int n;
        resetn = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_start",     {31'b0, mca_start}, 32'd0);
        check("rst_busy",      {31'b0, busy}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        check("rst_operands",  mca_operands[5] | mca_operands[15], 32'd0);
        resetn = 1'b1;
        step();

        // 1..16, continuous
        for (int i = 0; i < N; i++) ops[i] = 32'(i + 1);
        load(1'b0);
        wait_out("t1", 0, 0, n);
        check("t1_latency", 32'(n), 32'd18);
        check("t1_sum", out_data, 32'd136);
        step();
        check("t1_handshake_valid", {31'b0, out_valid}, 32'd0);
        check("t1_back_to_load", {31'b0, in_ready}, 32'd1);

        // signed wraparound
        fill(32'd0); ops[0] = 32'h7FFF_FFFF; ops[1] = 32'd1;
        load(1'b0);
        wait_out("t2", 0, 0, n);
        check("t2_wrap", out_data, 32'h8000_0000);
        step();

        fill(32'hFFFF_FFFB);
        load(1'b0);
        wait_out("t3", 0, 0, n);
        check("t3_neg80", out_data, 32'hFFFF_FFB0);
        step();

        // gapped input beats, junk on idle cycles
        fill(32'd3);
        load(1'b1);
        wait_out("t4", 0, 0, n);
        check("t4_sum48", out_data, 32'd48);
        step();

        // enable dropped 5 cycles mid-WAIT
        fill(32'd7);
        load(1'b0);
        wait_out("t5", 5, 5, n);
        check("t5_latency", 32'(n), 32'd23);
        check("t5_sum", out_data, 32'd112);
        step();

        // back-pressure, stray in_valid while held
        fill(32'd9);
        out_ready = 1'b0;
        load(1'b0);
        wait_out("t6", 0, 0, n);
        check("t6_sum", out_data, 32'd144);
        in_valid = 1'b1; in_data = 32'd99;
        for (int k = 0; k < 10; k++) step();
        check("t6_hold_data",  out_data, 32'd144);
        check("t6_hold_valid", {31'b0, out_valid}, 32'd1);
        check("t6_hold_rdy",   {31'b0, in_ready}, 32'd0);
        check("t6_hold_busy",  {31'b0, busy}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("t6_release_busy",  {31'b0, busy}, 32'd0);
        check("t6_release_valid", {31'b0, out_valid}, 32'd0);
        fill(32'd10);
        load(1'b0);
        wait_out("t7", 0, 0, n);
        check("t7_sum160", out_data, 32'd160);
        step();

        // reset during WAIT
        fill(32'd5);
        load(1'b0);
        for (int k = 0; k < 6; k++) step();
        check("t8_busy_pre", {31'b0, busy}, 32'd1);
        resetn = 1'b0;
        #2;
        check("t8_rst_busy",     {31'b0, busy}, 32'd0);
        check("t8_rst_data",     out_data, 32'd0);
        check("t8_rst_valid",    {31'b0, out_valid}, 32'd0);
        check("t8_rst_operands", mca_operands[0] | mca_operands[15], 32'd0);
        step();
        resetn = 1'b1;
        step();
        fill(32'd2);
        load(1'b0);
        wait_out("t9", 0, 0, n);
        check("t9_latency", 32'(n), 32'd18);
        check("t9_sum32", out_data, 32'd32);
        step();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
